// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the LEGv8 run/step/halt controller:
// the FSM state encoding, its width and the default HLT opcode.
package cpu_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [31:0] HLT_ENC_DEFAULT = 32'hD440_0000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_BREAK = 3'd3,
    ST_HALT  = 3'd4
  } cpu_state_e;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debouncer. A new input level is
// accepted only after it has differed from the accepted level for
// DEB_CYCLES consecutive clocks. The accepted level's rising edge is
// reported as a one-cycle pulse.
module sync_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          meta_reg;
  logic          sync_reg;
  logic          stable_reg;
  logic          pulse_reg;
  logic [CW-1:0] cnt_reg;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level once the
  // count has run its course. The pulse is raised on the same edge that
  // accepts a high level, so it is aligned with the stable level's rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
      pulse_reg  <= 1'b0;
    end else begin
      pulse_reg <= 1'b0;
      if (sync_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
        stable_reg <= sync_reg;
        cnt_reg    <= '0;
        pulse_reg  <= sync_reg;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/cpu_run_controller.sv
// Run/step/halt sequencer for the single-cycle LEGv8 core. cpu_en is the
// one qualifier for PC load, RF write and DMIO write; an instruction that
// triggers a stop (HLT or breakpoint) never retires.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int          PC_W       = 64,
  parameter int          CNT_W      = 32,
  parameter int          DEB_CYCLES = 16,
  parameter logic [31:0] HLT_ENC    = HLT_ENC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_sw,
  input  logic               step_btn,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  input  logic [PC_W-1:0]    pc,
  input  logic [31:0]        instr,
  output logic               cpu_en,
  output logic [STATE_W-1:0] state,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [STATE_W-1:0] IDLE  = ST_IDLE;
  localparam logic [STATE_W-1:0] RUN   = ST_RUN;
  localparam logic [STATE_W-1:0] STEP  = ST_STEP;
  localparam logic [STATE_W-1:0] BREAK = ST_BREAK;
  localparam logic [STATE_W-1:0] HALT  = ST_HALT;

  logic               run_meta_reg;
  logic               run_s_reg;
  logic               run_q_reg;
  logic               run_rise;
  logic               step_pulse;
  logic               stop_hlt;
  logic               stop_bp;
  logic               bp_skip_reg;
  logic               bp_rearm;
  logic [STATE_W-1:0] state_reg;
  logic [STATE_W-1:0] state_next;
  logic [CNT_W-1:0]   retired_reg;

  // Run switch: plain 2-flop synchronizer plus one extra flop for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_meta_reg <= 1'b0;
      run_s_reg    <= 1'b0;
      run_q_reg    <= 1'b0;
    end else begin
      run_meta_reg <= run_sw;
      run_s_reg    <= run_meta_reg;
      run_q_reg    <= run_s_reg;
    end
  end

  assign run_rise = run_s_reg & ~run_q_reg;

  sync_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_db (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (step_btn),
    .pulse (step_pulse)
  );

  assign stop_hlt = (instr == HLT_ENC);
  assign stop_bp  = bp_en & (pc == bp_addr) & ~bp_skip_reg;

  assign cpu_en = ((state_reg == RUN) | (state_reg == STEP)) & ~stop_hlt & ~stop_bp
                & ~((state_reg == RUN) & ~run_s_reg);

  // Next-state selection; HLT is tested before the breakpoint so it wins.
  always_comb begin
    state_next = state_reg;
    bp_rearm   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run_s_reg)       state_next = RUN;
        else if (step_pulse) state_next = STEP;
      end
      RUN: begin
        if (stop_hlt)        state_next = HALT;
        else if (stop_bp)    state_next = BREAK;
        else if (!run_s_reg) state_next = IDLE;
      end
      STEP: begin
        if (stop_hlt)        state_next = HALT;
        else if (stop_bp)    state_next = BREAK;
        else                 state_next = IDLE;
      end
      BREAK: begin
        if (step_pulse) begin
          state_next = STEP;
          bp_rearm   = 1'b1;
        end else if (run_rise) begin
          state_next = RUN;
          bp_rearm   = 1'b1;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // State register, breakpoint skip flag and saturating retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bp_skip_reg <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (bp_rearm)    bp_skip_reg <= 1'b1;
      else if (cpu_en) bp_skip_reg <= 1'b0;
      if (cpu_en && (retired_reg != {CNT_W{1'b1}}))
        retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign state   = state_reg;
  assign halted  = (state_reg == HALT);
  assign retired = retired_reg;

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Run/step/halt sequencer for the single-cycle LEGv8 CPU.
- Produces `cpu_en`, the single qualifier for all CPU state updates: PC load, RF write and DMIO write.
- Takes a run switch and a step button from the board. Stops the core on a HLT instruction or on a PC breakpoint. Counts retired instructions.
- Sits between board I/O and the PC/RF/DMIO enables in the top-level CPU.

Parameters:
- PC_W, 64, width of the program counter and breakpoint address.
- CNT_W, 32, width of the retired-instruction counter.
- DEB_CYCLES, 16, number of stable cycles required to accept a new step-button level (≥2).
- HLT_ENC, 32'hD440_0000, instruction encoding treated as HLT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- run_sw  in  1  asynchronous run switch (level).
- step_btn  in  1  asynchronous step push-button (bouncy).
- bp_en  in  1  breakpoint enable (quasi-static).
- bp_addr  in  PC_W  breakpoint PC (quasi-static).
- pc  in  PC_W  current PC from the PC register.
- instr  in  32  current instruction from IM.
- cpu_en  out  1  the current instruction retires at this clock edge.
- state  out  3  FSM state encoding: IDLE=0, RUN=1, STEP=2, BREAK=3, HALT=4.
- halted  out  1  high in HALT (HLT encountered).
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- **Reset** (rst_n=0, asynchronous): state=IDLE; cpu_en=0; halted=0; retired=0; synchronizers, debounce counter, stable level and bp_skip all cleared. Reset mid-RUN aborts immediately; the instruction in flight does not retire.
- **Synchronizers:** run_sw and step_btn each pass through a 2-FF synchronizer, giving run_s and step_s.
  - run_rise = run_s & ~run_s_q.
- **Step debounce:**
  - The counter resets whenever step_s == step_stable, and increments otherwise.
  - When the counter reaches DEB_CYCLES-1 while still differing, step_stable <= step_s and the counter clears.
  - step_pulse is a one-cycle pulse on the rising edge of step_stable.
  - Latency from a clean step_btn rise to step_pulse is 2+DEB_CYCLES cycles.
  - Any glitch shorter than DEB_CYCLES cycles produces no pulse.
- **Stop condition (combinational):**
  - stop_hlt = (instr == HLT_ENC).
  - stop_bp = bp_en & (pc == bp_addr) & ~bp_skip.
- **cpu_en (combinational):** (state==RUN | state==STEP) & ~stop_hlt & ~stop_bp & ~(state==RUN & ~run_s). A stopping instruction is never retired.
- **Transitions, IDLE:**
  - run_s → RUN.
  - else step_pulse → STEP.
  - run_s and step_pulse together: RUN wins and the step is discarded.
- **Transitions, RUN:**
  - stop_hlt → HALT.
  - else stop_bp → BREAK.
  - else ~run_s → IDLE.
  - else stay in RUN.
- **Transitions, STEP** (lasts exactly one cycle):
  - stop_hlt → HALT.
  - else stop_bp → BREAK.
  - else → IDLE.
  - A step into an instruction that is already stopping retires nothing.
- **Transitions, BREAK:**
  - step_pulse → STEP.
  - else run_rise → RUN. A held run switch does not resume; it must be toggled.
  - On exit, bp_skip <= 1 so the breakpoint instruction itself executes.
- **bp_skip:** cleared on the first cycle with cpu_en=1, and also cleared on reset.
- **HALT:** terminal; only rst_n leaves it. halted=1 and cpu_en=0.
- **Priority:** HLT beats breakpoint when both match on the same instruction.
- **retired:** increments by 1 at every edge with cpu_en=1. It saturates at all-ones and never wraps.
- **Breakpoint address:** compared over the full PC_W bits; no alignment masking.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the state enum (IDLE, RUN, STEP, BREAK, HALT; 3 bits);
  - the HLT_ENC default constant;
  - the state width constant.
- Sub-module sync_debounce (parameter DEB_CYCLES) contains the 2-FF synchronizer, stable-level register and counter, and outputs a rising-edge pulse. It is instantiated for step_btn.
- run_sw uses a plain 2-FF synchronizer in the top level.

Test Plan:
- **Run and stop:** reset, run_sw=1, instr stream of 5 non-HLT words then HLT_ENC at pc=0x14 → cpu_en high 5 cycles; state HALT; halted=1; retired=5; run_sw toggling afterwards has no effect.
- **Step with bounce:** in IDLE, step_btn bounces 3 times for <DEB_CYCLES each, then holds high → exactly one STEP cycle, retired +1, return to IDLE; a bounce-only press gives no step.
- **Breakpoint resume:** bp_en=1, bp_addr=0x8, run → BREAK with pc=0x8 and retired=2. Step → instruction at 0x8 retires (bp_skip), retired=3, IDLE. Breakpoint re-arms on the next visit to 0x8.
- **Run-switch edge rules:** in BREAK with run_sw held high → remains BREAK; run_sw 0→1 → RUN. In RUN, run_sw 0 → IDLE with cpu_en=0 in the same cycle.
- **Priority and concurrency:** HLT_ENC located at bp_addr → HALT, not BREAK. run_s and step_pulse in the same IDLE cycle → RUN, no STEP.
- **Saturation and reset:** force retired to 2^CNT_W-2 and run 3 cycles → retired=all-ones. Assert rst_n low mid-RUN → outputs zero/IDLE asynchronously, before the next clk edge.
